// File: rtl/avalon_mm_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM register arbiter.
package avalon_mm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    typedef logic grant_t;

    localparam grant_t GRANT_M0 = 1'b0;
    localparam grant_t GRANT_M1 = 1'b1;

    // Replicated to DWIDTH where used to form the timeout read response.
    localparam logic RD_ERR_DATA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic; last_grant advances only on the update strobe.
module rr_arb2
    import avalon_mm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  grant_t     done_grant,
    output logic       grant_valid,
    output grant_t     grant
);

    grant_t last_grant_r;

    // Remember the most recent master that completed a transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= GRANT_M1;
        end else if (update) begin
            last_grant_r <= done_grant;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Pick the lone requester, or the one that did not go last on contention.
    always_comb begin
        grant       = GRANT_M0;
        grant_valid = 1'b0;
        case (req)
            2'b01: begin
                grant       = GRANT_M0;
                grant_valid = 1'b1;
            end
            2'b10: begin
                grant       = GRANT_M1;
                grant_valid = 1'b1;
            end
            2'b11: begin
                grant       = ~last_grant_r;
                grant_valid = 1'b1;
            end
            default: begin
                grant       = GRANT_M0;
                grant_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM register slave between two masters,
// one transaction in flight, with a read-timeout guard against a silent slave.
module avalon_mm_arbiter
    import avalon_mm_arb_pkg::*;
#(
    parameter  int DWIDTH     = 32,
    parameter  int NUM_REGS   = 4,
    parameter  int RD_TIMEOUT = 16,
    localparam int AWIDTH     = $clog2(NUM_REGS) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AWIDTH-1:0] m0_address_i,
    input  logic              m0_write_i,
    input  logic [DWIDTH-1:0] m0_writedata_i,
    input  logic              m0_read_i,
    output logic              m0_waitrequest_o,
    output logic [DWIDTH-1:0] m0_readdata_o,
    output logic              m0_readdatavalid_o,
    input  logic [AWIDTH-1:0] m1_address_i,
    input  logic              m1_write_i,
    input  logic [DWIDTH-1:0] m1_writedata_i,
    input  logic              m1_read_i,
    output logic              m1_waitrequest_o,
    output logic [DWIDTH-1:0] m1_readdata_o,
    output logic              m1_readdatavalid_o,
    output logic [AWIDTH-1:0] s_address_o,
    output logic              s_write_o,
    output logic [DWIDTH-1:0] s_writedata_o,
    output logic              s_read_o,
    input  logic              s_waitrequest_i,
    input  logic [DWIDTH-1:0] s_readdata_i,
    input  logic              s_readdatavalid_i
);

    localparam int                CWIDTH   = $clog2(RD_TIMEOUT);
    localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(RD_TIMEOUT - 1);

    state_t              state_r;
    state_t              state_next_s;
    grant_t              grant_r;
    logic [CWIDTH-1:0]   cnt_r;
    logic [DWIDTH-1:0]   rdata0_r;
    logic [DWIDTH-1:0]   rdata1_r;
    logic [1:0]          rdv_r;

    logic [1:0]          req_s;
    logic                arb_valid_s;
    grant_t              arb_grant_s;
    logic [AWIDTH-1:0]   g_addr_s;
    logic                g_write_s;
    logic [DWIDTH-1:0]   g_wdata_s;
    logic                g_read_s;
    logic                wr_acc_s;
    logic                rd_acc_s;
    logic                rd_done_s;
    logic                upd_s;
    logic [DWIDTH-1:0]   rd_value_s;

    assign req_s = {m1_read_i | m1_write_i, m0_read_i | m0_write_i};

    rr_arb2 u_rr_arb2 (
        .clk         (clk_i),
        .rst         (rst_i),
        .req         (req_s),
        .update      (upd_s),
        .done_grant  (grant_r),
        .grant_valid (arb_valid_s),
        .grant       (arb_grant_s)
    );

    // Route the granted master's request lines toward the slave.
    always_comb begin
        if (grant_r == GRANT_M1) begin
            g_addr_s  = m1_address_i;
            g_write_s = m1_write_i;
            g_wdata_s = m1_writedata_i;
            g_read_s  = m1_read_i;
        end else begin
            g_addr_s  = m0_address_i;
            g_write_s = m0_write_i;
            g_wdata_s = m0_writedata_i;
            g_read_s  = m0_read_i;
        end
    end

    // A simultaneous read and write is treated as a write.
    assign wr_acc_s   = (state_r == BUSY) && g_write_s && !s_waitrequest_i;
    assign rd_acc_s   = (state_r == BUSY) && !g_write_s && g_read_s && !s_waitrequest_i;
    assign rd_done_s  = (state_r == WAIT_RD) && (s_readdatavalid_i || (cnt_r == CNT_LAST));
    assign upd_s      = wr_acc_s | rd_done_s;
    assign rd_value_s = s_readdatavalid_i ? s_readdata_i : {DWIDTH{RD_ERR_DATA}};

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (!g_write_s && !g_read_s) begin
                    state_next_s = IDLE;
                end else if (wr_acc_s) begin
                    state_next_s = IDLE;
                end else if (rd_acc_s) begin
                    state_next_s = WAIT_RD;
                end else begin
                    state_next_s = BUSY;
                end
            end
            WAIT_RD: begin
                if (rd_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_RD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM outputs: the slave and the granted master see each other only in BUSY.
    always_comb begin
        s_address_o      = g_addr_s;
        s_writedata_o    = g_wdata_s;
        s_write_o        = 1'b0;
        s_read_o         = 1'b0;
        m0_waitrequest_o = 1'b1;
        m1_waitrequest_o = 1'b1;
        case (state_r)
            BUSY: begin
                s_write_o = g_write_s;
                s_read_o  = g_read_s & ~g_write_s;
                if (grant_r == GRANT_M1) begin
                    m1_waitrequest_o = s_waitrequest_i;
                end else begin
                    m0_waitrequest_o = s_waitrequest_i;
                end
            end
            default: begin
                s_write_o = 1'b0;
                s_read_o  = 1'b0;
            end
        endcase
    end

    // Grant capture, read-timeout counter and registered read response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_r  <= GRANT_M0;
            cnt_r    <= {CWIDTH{1'b0}};
            rdata0_r <= {DWIDTH{1'b0}};
            rdata1_r <= {DWIDTH{1'b0}};
            rdv_r    <= 2'b00;
        end else begin
            rdv_r <= 2'b00;
            if ((state_r == IDLE) && arb_valid_s) begin
                grant_r <= arb_grant_s;
            end else begin
                grant_r <= grant_r;
            end
            if (rd_acc_s) begin
                cnt_r <= {CWIDTH{1'b0}};
            end else if (state_r == WAIT_RD) begin
                cnt_r <= cnt_r + CWIDTH'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (rd_done_s && (grant_r == GRANT_M1)) begin
                rdata1_r <= rd_value_s;
                rdv_r[1] <= 1'b1;
            end else if (rd_done_s) begin
                rdata0_r <= rd_value_s;
                rdv_r[0] <= 1'b1;
            end else begin
                rdata0_r <= rdata0_r;
                rdata1_r <= rdata1_r;
            end
        end
    end

    assign m0_readdata_o      = rdata0_r;
    assign m1_readdata_o      = rdata1_r;
    assign m0_readdatavalid_o = rdv_r[0];
    assign m1_readdatavalid_o = rdv_r[1];

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench for avalon_mm_arbiter: contention, write, read, timeout, stall, async reset.
module tb_avalon_mm_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  m0_address, m1_address, s_address;
    logic        m0_write, m1_write, m0_read, m1_read;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_write, s_read, s_waitrequest, s_readdatavalid;
    logic [31:0] s_readdata;

    int checks;
    int failures;

    avalon_mm_arbiter #(.DWIDTH(32), .NUM_REGS(4), .RD_TIMEOUT(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .m0_address_i       (m0_address),
        .m0_write_i         (m0_write),
        .m0_writedata_i     (m0_writedata),
        .m0_read_i          (m0_read),
        .m0_waitrequest_o   (m0_waitrequest),
        .m0_readdata_o      (m0_readdata),
        .m0_readdatavalid_o (m0_readdatavalid),
        .m1_address_i       (m1_address),
        .m1_write_i         (m1_write),
        .m1_writedata_i     (m1_writedata),
        .m1_read_i          (m1_read),
        .m1_waitrequest_o   (m1_waitrequest),
        .m1_readdata_o      (m1_readdata),
        .m1_readdatavalid_o (m1_readdatavalid),
        .s_address_o        (s_address),
        .s_write_o          (s_write),
        .s_writedata_o      (s_writedata),
        .s_read_o           (s_read),
        .s_waitrequest_i    (s_waitrequest),
        .s_readdata_i       (s_readdata),
        .s_readdatavalid_i  (s_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_m1;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        m0_address = 3'd0; m1_address = 3'd0;
        m0_write = 1'b0; m1_write = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
        m0_writedata = 32'd0; m1_writedata = 32'd0;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = 32'hDEAD_BEEF;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_bit("rst_m0_wait", m0_waitrequest, 1'b1);
        chk_bit("rst_m1_wait", m1_waitrequest, 1'b1);
        chk_bit("rst_s_write", s_write, 1'b0);
        chk_bit("rst_s_read", s_read, 1'b0);
        chk_bit("rst_m0_rdv", m0_readdatavalid, 1'b0);
        chk_word("rst_m0_rdata", m0_readdata, 32'd0);

        // Both masters write continuously: grants alternate m0, m1, m0, m1
        m0_write = 1'b1; m0_address = 3'd1; m0_writedata = 32'h0000_0100;
        m1_write = 1'b1; m1_address = 3'd2; m1_writedata = 32'h0000_0200;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_m1 = (i % 2) == 1;
            cyc();
            chk_bit("cont_s_write", s_write, 1'b1);
            chk_word("cont_wdata", s_writedata, exp_m1 ? 32'h0000_0200 : 32'h0000_0100);
            chk_bit("cont_m0_wait", m0_waitrequest, exp_m1);
            chk_bit("cont_m1_wait", m1_waitrequest, ~exp_m1);
            cyc();
            chk_bit("cont_idle_s_write", s_write, 1'b0);
            chk_bit("cont_idle_m0_wait", m0_waitrequest, 1'b1);
        end
        m0_write = 1'b0; m1_write = 1'b0;

        // Single m0 write, no slave stall
        cyc();
        m0_write = 1'b1; m0_address = 3'd1; m0_writedata = 32'hA5A5_0001;
        #1;
        chk_bit("wr_req_s_write", s_write, 1'b0);
        chk_bit("wr_req_m0_wait", m0_waitrequest, 1'b1);
        cyc();
        chk_bit("wr_s_write", s_write, 1'b1);
        chk_word("wr_s_addr", {29'd0, s_address}, 32'd1);
        chk_word("wr_s_wdata", s_writedata, 32'hA5A5_0001);
        chk_bit("wr_m0_wait", m0_waitrequest, 1'b0);
        chk_bit("wr_m1_wait", m1_waitrequest, 1'b1);
        cyc();
        m0_write = 1'b0;
        #1;
        chk_bit("wr_done_s_write", s_write, 1'b0);
        chk_bit("wr_done_m0_wait", m0_waitrequest, 1'b1);

        // m1 read, slave answers three cycles after accept
        m1_read = 1'b1; m1_address = 3'd2;
        cyc();
        chk_bit("rd_s_read", s_read, 1'b1);
        chk_word("rd_s_addr", {29'd0, s_address}, 32'd2);
        chk_bit("rd_m1_wait", m1_waitrequest, 1'b0);
        cyc();
        m1_read = 1'b0;
        #1;
        chk_bit("rd_wait_s_read", s_read, 1'b0);
        chk_bit("rd_wait_m1_wait", m1_waitrequest, 1'b1);
        repeat (3) cyc();
        s_readdatavalid = 1'b1; s_readdata = 32'h1234_5678;
        #1;
        chk_bit("rd_pre_m1_rdv", m1_readdatavalid, 1'b0);
        cyc();
        s_readdatavalid = 1'b0; s_readdata = 32'hDEAD_BEEF;
        #1;
        chk_bit("rd_m1_rdv", m1_readdatavalid, 1'b1);
        chk_word("rd_m1_rdata", m1_readdata, 32'h1234_5678);
        chk_bit("rd_m0_rdv", m0_readdatavalid, 1'b0);
        cyc();
        chk_bit("rd_m1_rdv_off", m1_readdatavalid, 1'b0);
        chk_word("rd_m1_rdata_hold", m1_readdata, 32'h1234_5678);

        // m0 read with a silent slave: error response after the timeout
        m0_read = 1'b1; m0_address = 3'd3;
        cyc();
        chk_bit("to_s_read", s_read, 1'b1);
        cyc();
        m0_read = 1'b0;
        for (int k = 1; k < 16; k++) begin
            cyc();
            chk_bit("to_m0_rdv_early", m0_readdatavalid, 1'b0);
        end
        cyc();
        chk_bit("to_m0_rdv", m0_readdatavalid, 1'b1);
        chk_word("to_m0_rdata", m0_readdata, 32'hFFFF_FFFF);
        chk_bit("to_m1_rdv", m1_readdatavalid, 1'b0);
        s_readdatavalid = 1'b1; s_readdata = 32'h0000_0055;
        cyc();
        s_readdatavalid = 1'b0; s_readdata = 32'hDEAD_BEEF;
        #1;
        chk_bit("stray_m0_rdv", m0_readdatavalid, 1'b0);
        chk_bit("stray_m1_rdv", m1_readdatavalid, 1'b0);
        cyc();
        chk_bit("stray_m0_rdv2", m0_readdatavalid, 1'b0);
        chk_word("stray_m0_rdata", m0_readdata, 32'hFFFF_FFFF);

        // m1 write stalled 5 cycles while m0 also requests
        s_waitrequest = 1'b1;
        m1_write = 1'b1; m1_address = 3'd3; m1_writedata = 32'hCAFE_0005;
        m0_write = 1'b1; m0_address = 3'd1; m0_writedata = 32'h0BAD_0000;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk_word("stall_wdata", s_writedata, 32'hCAFE_0005);
            chk_word("stall_addr", {29'd0, s_address}, 32'd3);
            chk_bit("stall_s_write", s_write, 1'b1);
            chk_bit("stall_m1_wait", m1_waitrequest, 1'b1);
            chk_bit("stall_m0_wait", m0_waitrequest, 1'b1);
            cyc();
        end
        s_waitrequest = 1'b0;
        #1;
        chk_bit("stall_rel_m1_wait", m1_waitrequest, 1'b0);
        chk_bit("stall_rel_m0_wait", m0_waitrequest, 1'b1);
        chk_word("stall_rel_wdata", s_writedata, 32'hCAFE_0005);
        cyc();
        m1_write = 1'b0;
        #1;
        chk_bit("stall_idle_s_write", s_write, 1'b0);
        chk_bit("stall_idle_m0_wait", m0_waitrequest, 1'b1);
        cyc();
        chk_word("stall_m0_wdata", s_writedata, 32'h0BAD_0000);
        chk_word("stall_m0_addr", {29'd0, s_address}, 32'd1);
        chk_bit("stall_m0_granted", m0_waitrequest, 1'b0);
        cyc();
        m0_write = 1'b0;

        // Asynchronous reset while waiting for read data
        m1_read = 1'b1; m1_address = 3'd0;
        cyc();
        cyc();
        m1_read = 1'b0;
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        chk_bit("arst_m1_rdv", m1_readdatavalid, 1'b0);
        chk_word("arst_m1_rdata", m1_readdata, 32'd0);
        chk_word("arst_m0_rdata", m0_readdata, 32'd0);
        chk_bit("arst_m1_wait", m1_waitrequest, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 32'h0000_0077;
        cyc();
        s_readdatavalid = 1'b0;
        #1;
        chk_bit("late_m1_rdv", m1_readdatavalid, 1'b0);
        chk_bit("late_m0_rdv", m0_readdatavalid, 1'b0);
        chk_word("late_m1_rdata", m1_readdata, 32'd0);
        m0_write = 1'b1; m0_address = 3'd2; m0_writedata = 32'h0000_0011;
        cyc();
        chk_bit("post_rst_s_write", s_write, 1'b1);
        chk_bit("post_rst_m0_wait", m0_waitrequest, 1'b0);
        chk_word("post_rst_wdata", s_writedata, 32'h0000_0011);
        cyc();
        m0_write = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
